// File: rtl/fnd_time_ctrl.sv
// Display-source controller for the 4-digit FND: switch debounce, watch/stopwatch handover, page select, dp blink.
// Optional feature macro FND_BLANK_EN: when defined, the handover blanks the display for BLANK_TICKS ticks.
module fnd_time_ctrl #(
  parameter int DB_TICKS    = 20,
  parameter int BLANK_TICKS = 200,
  parameter int BLINK_TICKS = 500
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_tick,
  input  logic        sw_src,
  input  logic        sw_page,
  input  logic [23:0] watch_time,
  input  logic [23:0] stop_watch_time,
  output logic [23:0] fnd_time,
  output logic        fnd_page,
  output logic        fnd_blank,
  output logic        dp_on,
  output logic        src_stopwatch
);

  localparam int DB_W = (DB_TICKS > 1) ? $clog2(DB_TICKS) : 1;
  localparam int PH_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

  // bit 0 = source switch, bit 1 = page switch
  logic [1:0] w_raw;
  logic [1:0] w_acc;
  assign w_raw = {sw_page, sw_src};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_db
      logic            r_s1;
      logic            r_s2;
      logic            r_acc;
      logic [DB_W-1:0] r_cnt;

      always_ff @(posedge clk) begin
        if (reset) begin
          r_s1  <= 1'b0;
          r_s2  <= 1'b0;
          r_acc <= 1'b0;
          r_cnt <= '0;
        end else begin
          r_s1 <= w_raw[gi];
          r_s2 <= r_s1;
          if (r_s2 == r_acc) begin
            r_cnt <= '0;
          end else if (i_tick) begin
            if (r_cnt == DB_W'(DB_TICKS - 1)) begin
              r_acc <= r_s2;
              r_cnt <= '0;
            end else begin
              r_cnt <= r_cnt + DB_W'(1);
            end
          end
        end
      end

      assign w_acc[gi] = r_acc;
    end
  endgenerate

  logic w_acc_src;
  logic w_acc_page;
  assign w_acc_src  = w_acc[0];
  assign w_acc_page = w_acc[1];

`ifdef FND_BLANK_EN
  localparam int BL_W = $clog2(BLANK_TICKS + 1);

  typedef enum logic [1:0] {
    SHOW_W     = 2'd0,
    BLANK_TO_S = 2'd1,
    SHOW_S     = 2'd2,
    BLANK_TO_W = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [BL_W-1:0] r_blank_cnt;
  logic            w_in_blank;
  logic            w_to_s;

  assign w_in_blank = (r_state == BLANK_TO_S) || (r_state == BLANK_TO_W);
  assign w_to_s     = (r_state == SHOW_S) || (r_state == BLANK_TO_S);

  // A reversal during the blank window returns to the origin without blanking.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      SHOW_W:     if (w_acc_src) w_state_next = BLANK_TO_S;
      SHOW_S:     if (!w_acc_src) w_state_next = BLANK_TO_W;
      BLANK_TO_S: begin
        if (!w_acc_src)              w_state_next = SHOW_W;
        else if (r_blank_cnt == '0) w_state_next = SHOW_S;
      end
      BLANK_TO_W: begin
        if (w_acc_src)               w_state_next = SHOW_S;
        else if (r_blank_cnt == '0) w_state_next = SHOW_W;
      end
      default:    w_state_next = SHOW_W;
    endcase
  end

  // The load cycle takes priority, so a tick coinciding with it is not counted.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_blank_cnt <= '0;
    end else if ((r_state != w_state_next) &&
                 ((w_state_next == BLANK_TO_S) || (w_state_next == BLANK_TO_W))) begin
      r_blank_cnt <= BL_W'(BLANK_TICKS);
    end else if (w_in_blank && i_tick && (r_blank_cnt != '0)) begin
      r_blank_cnt <= r_blank_cnt - BL_W'(1);
    end
  end
`else
  typedef enum logic {
    SHOW_W = 1'b0,
    SHOW_S = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_next;
  logic   w_in_blank;
  logic   w_to_s;

  assign w_in_blank = 1'b0;
  assign w_to_s     = (r_state == SHOW_S);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      SHOW_W:  if (w_acc_src) w_state_next = SHOW_S;
      SHOW_S:  if (!w_acc_src) w_state_next = SHOW_W;
      default: w_state_next = SHOW_W;
    endcase
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) r_state <= SHOW_W;
    else       r_state <= w_state_next;
  end

  logic [23:0]     r_fnd_time;
  logic            r_fnd_page;
  logic            r_fnd_blank;
  logic            r_src;
  logic            r_dp_on;
  logic            r_blink;
  logic [PH_W-1:0] r_phase;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fnd_time  <= 24'h0;
      r_fnd_page  <= 1'b0;
      r_fnd_blank <= 1'b0;
      r_src       <= 1'b0;
      r_dp_on     <= 1'b1;
    end else begin
      if (r_state == SHOW_W)      r_fnd_time <= watch_time;
      else if (r_state == SHOW_S) r_fnd_time <= stop_watch_time;
      else                        r_fnd_time <= 24'h0;
      // Page is frozen while blanking; the pending value lands on the first SHOW cycle.
      if (!w_in_blank) r_fnd_page <= w_acc_page;
      r_fnd_blank <= w_in_blank;
      r_src       <= w_to_s;
      r_dp_on     <= w_in_blank ? 1'b0 : r_blink;
    end
  end

  // Any state change restarts the blink phase with the dp lit.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_phase <= '0;
      r_blink <= 1'b1;
    end else if (r_state != w_state_next) begin
      r_phase <= '0;
      r_blink <= 1'b1;
    end else if (i_tick) begin
      if (r_phase == PH_W'(BLINK_TICKS - 1)) begin
        r_phase <= '0;
        r_blink <= ~r_blink;
      end else begin
        r_phase <= r_phase + PH_W'(1);
      end
    end
  end

  assign fnd_time      = r_fnd_time;
  assign fnd_page      = r_fnd_page;
`ifdef FND_BLANK_EN
  assign fnd_blank     = r_fnd_blank;
`else
  assign fnd_blank     = 1'b0;
`endif
  assign dp_on         = r_dp_on;
  assign src_stopwatch = r_src;

endmodule

// File: tb/tb_fnd_time_ctrl.sv
// Directed bench for fnd_time_ctrl: reset, handover, page freeze, bounce, reversal, mid-handover reset and blink.
module tb_fnd_time_ctrl;

`ifdef FND_BLANK_EN
  localparam bit BLANK_EN = 1'b1;
`else
  localparam bit BLANK_EN = 1'b0;
`endif

  localparam logic [23:0] STOP_T = 24'h001F05;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_tick;
  logic        sw_src;
  logic        sw_page;
  logic [23:0] watch_time;
  logic [23:0] stop_watch_time;
  logic [23:0] fnd_time;
  logic        fnd_page;
  logic        fnd_blank;
  logic        dp_on;
  logic        src_stopwatch;

  int n_checks = 0;
  int n_fail   = 0;

  fnd_time_ctrl #(
    .DB_TICKS   (20),
    .BLANK_TICKS(200),
    .BLINK_TICKS(500)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .i_tick         (i_tick),
    .sw_src         (sw_src),
    .sw_page        (sw_page),
    .watch_time     (watch_time),
    .stop_watch_time(stop_watch_time),
    .fnd_time       (fnd_time),
    .fnd_page       (fnd_page),
    .fnd_blank      (fnd_blank),
    .dp_on          (dp_on),
    .src_stopwatch  (src_stopwatch)
  );

  always #5 clk = ~clk;

  task automatic clk1();
    @(posedge clk);
    #1;
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      i_tick = 1'b1;
      clk1();
      i_tick = 1'b0;
      clk1();
    end
  endtask

  task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
    $display("check %-22s observed %h expected %h", tag, obs, exp);
  endtask

  initial begin
    reset           = 1'b1;
    i_tick          = 1'b0;
    sw_src          = 1'b1;
    sw_page         = 1'b0;
    watch_time      = 24'h0A1234;
    stop_watch_time = STOP_T;
    repeat (3) clk1();
    reset = 1'b0;

    // Reset values, with sw_src held high through reset
    check("rst_time",  fnd_time,             24'h0);
    check("rst_page",  {23'h0, fnd_page},    24'h0);
    check("rst_blank", {23'h0, fnd_blank},   24'h0);
    check("rst_src",   {23'h0, src_stopwatch}, 24'h0);
    check("rst_dp",    {23'h0, dp_on},       24'h1);
    clk1();
    check("post_rst_time", fnd_time, 24'h0A1234);
    watch_time = 24'h0A1235;
    clk1();
    check("track_watch", fnd_time, 24'h0A1235);

    // Handover to stopwatch: debounce boundary at tick 19/20
    tick(19);
    clk1();
    check("db_19_src", {23'h0, src_stopwatch}, 24'h0);
    tick(1);
    clk1();
    check("ho_src",   {23'h0, src_stopwatch}, 24'h1);
    check("ho_blank", {23'h0, fnd_blank}, {23'h0, BLANK_EN});
    check("ho_time",  fnd_time, BLANK_EN ? 24'h0 : STOP_T);
    check("ho_dp",    {23'h0, dp_on}, {23'h0, ~BLANK_EN});

    // Page flip inside the blank window
    sw_page = 1'b1;
    clk1();
    clk1();
    tick(100);
    check("page_mid",   {23'h0, fnd_page}, {23'h0, ~BLANK_EN});
    tick(99);
    check("blank_199",  {23'h0, fnd_blank}, {23'h0, BLANK_EN});
    check("page_199",   {23'h0, fnd_page}, {23'h0, ~BLANK_EN});
    tick(1);
    clk1();
    check("blank_end",  {23'h0, fnd_blank}, 24'h0);
    check("show_s_time", fnd_time, STOP_T);
    check("page_show_s", {23'h0, fnd_page}, 24'h1);
    check("show_s_src", {23'h0, src_stopwatch}, 24'h1);

    // Handover back to watch
    sw_src = 1'b0;
    clk1();
    clk1();
    tick(20);
    clk1();
    check("ho_w_src",   {23'h0, src_stopwatch}, 24'h0);
    check("ho_w_blank", {23'h0, fnd_blank}, {23'h0, BLANK_EN});
    check("ho_w_time",  fnd_time, BLANK_EN ? 24'h0 : 24'h0A1235);
    tick(200);
    clk1();
    check("show_w_blank", {23'h0, fnd_blank}, 24'h0);
    check("show_w_time",  fnd_time, 24'h0A1235);

    // Reversal: source reverts while blank_cnt = 100
    sw_src = 1'b1;
    clk1();
    clk1();
    tick(20);
    tick(80);
    check("rev_pre_blank", {23'h0, fnd_blank}, {23'h0, BLANK_EN});
    sw_src = 1'b0;
    clk1();
    clk1();
    tick(20);
    clk1();
    check("rev_blank", {23'h0, fnd_blank}, 24'h0);
    check("rev_time",  fnd_time, 24'h0A1235);
    check("rev_src",   {23'h0, src_stopwatch}, 24'h0);
    tick(300);
    check("rev_no_blank", {23'h0, fnd_blank}, 24'h0);
    check("rev_stay_w",   {23'h0, src_stopwatch}, 24'h0);

    // Bounce: toggle every 5 ticks for 100 ticks, then settle at 0
    for (int i = 0; i < 20; i++) begin
      sw_src = ~sw_src;
      tick(5);
      check("bounce_src", {23'h0, src_stopwatch}, 24'h0);
    end
    sw_src = 1'b0;
    clk1();
    clk1();
    clk1();
    tick(25);
    check("bounce_src_end", {23'h0, src_stopwatch}, 24'h0);
    check("bounce_time",    fnd_time, 24'h0A1235);

    // Reset in the middle of a handover
    sw_src = 1'b1;
    clk1();
    clk1();
    tick(20);
    tick(50);
    check("pre_mrst_src", {23'h0, src_stopwatch}, 24'h1);
    reset   = 1'b1;
    sw_src  = 1'b0;
    sw_page = 1'b0;
    clk1();
    reset = 1'b0;
    check("mrst_src",   {23'h0, src_stopwatch}, 24'h0);
    check("mrst_blank", {23'h0, fnd_blank}, 24'h0);
    check("mrst_time",  fnd_time, 24'h0);
    check("mrst_page",  {23'h0, fnd_page}, 24'h0);
    check("mrst_dp",    {23'h0, dp_on}, 24'h1);

    // Blink in SHOW_W: toggles at ticks 500, 1000, 1500
    tick(499);
    check("dp_499",  {23'h0, dp_on}, 24'h1);
    tick(1);
    check("dp_500",  {23'h0, dp_on}, 24'h0);
    tick(499);
    check("dp_999",  {23'h0, dp_on}, 24'h0);
    tick(1);
    check("dp_1000", {23'h0, dp_on}, 24'h1);
    tick(500);
    check("dp_1500", {23'h0, dp_on}, 24'h0);

    // A state change forces dp_on high and restarts the phase
    tick(200);
    sw_src = 1'b1;
    clk1();
    clk1();
    tick(20);
    clk1();
    check("dp_force", {23'h0, dp_on}, {23'h0, ~BLANK_EN});
`ifdef FND_BLANK_EN
    tick(200);
    clk1();
`endif
    check("dp_show_s", {23'h0, dp_on}, 24'h1);
    tick(499);
    check("dp_rst_499", {23'h0, dp_on}, 24'h1);
    tick(1);
    check("dp_rst_500", {23'h0, dp_on}, 24'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
